// File: rtl/pll_seq_pkg.sv
// Shared definitions for the SDRAM PLL lock sequencer: FSM state
// encoding, default tuning constants and width helpers.
package pll_seq_pkg;

  // Sequencer states. The encoding is 3 bits wide, so three codes are unused
  // and are steered back to RESET_PLL by the FSM.
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_e;

  // Default tuning for a 50 MHz reference clock.
  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_MAX_RETRIES         = 3;
  localparam int unsigned DEF_LOSS_CNT_W          = 8;

  // Width needed to index n distinct values, never narrower than one bit.
  function automatic int unsigned width_min1(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of the single cycle counter shared by every timed state. It is
  // sized from the longest interval.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return width_min1(m);
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_lock_sync.sv
// Brings the asynchronous PLL locked flag into the refclk domain. It also
// flags the cycle on which the synchronized lock first drops.
module lock_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic locked_s_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic fall_q;

  // Two-stage synchronizer. The fall pulse is high exactly on the first cycle
  // that the second stage reads low after reading high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      fall_q  <= sync2_q & ~sync1_q;
    end
  end

  assign locked_s_o = sync2_q;
  assign fall_o     = fall_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// SDRAM PLL lock sequencer. The block pulses the PLL reset and waits for
// lock, with a bounded number of retries. It qualifies lock for a stable
// window before releasing the outclk-domain reset. In RUN it watches for
// lock loss, and it latches a fault if lock is never achieved.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned LOSS_CNT_W          = DEF_LOSS_CNT_W,
  localparam int unsigned RETRY_W            = width_min1(MAX_RETRIES + 1)
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  relock_req,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  fault,
  output logic [RETRY_W-1:0]    retry_count,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int unsigned CNT_W =
    cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);

  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [RETRY_W-1:0]    retry_t;
  typedef logic [LOSS_CNT_W-1:0] loss_t;

  // The synchronized lock was already high for one cycle in WAIT_LOCK before
  // STABLE is entered. That cycle counts toward the stable window, so STABLE
  // itself ends one count early. A one-cycle window skips STABLE entirely.
  localparam bit   DIRECT_RUN  = (LOCK_STABLE_CYCLES < 2);
  localparam cnt_t RST_LAST    = cnt_t'(RST_PULSE_CYCLES - 1);
  localparam cnt_t TO_LAST     = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
  localparam cnt_t STABLE_LAST =
    cnt_t'((LOCK_STABLE_CYCLES >= 2) ? (LOCK_STABLE_CYCLES - 2) : 0);
  localparam retry_t RETRY_MAX = retry_t'(MAX_RETRIES);
  localparam loss_t  LOSS_MAX  = '1;

  logic       locked_s;
  logic       lock_fall;

  pll_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  retry_t     retry_q, retry_d;
  loss_t      loss_q, loss_d;
  logic       pll_rst_q;
  logic       sys_rst_q;
  logic       ready_q;
  logic       fault_q;

  lock_sync u_lock_sync (
    .clk_i      (refclk),
    .rst_i      (rst),
    .async_i    (pll_locked),
    .locked_s_o (locked_s),
    .fall_o     (lock_fall)
  );

  // Next-state logic. This covers the transitions, retry bookkeeping, the
  // saturating loss count and the shared interval counter.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    unique case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = DIRECT_RUN ? RUN : STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = FAULT;
          end else begin
            retry_d = retry_q + retry_t'(1);
            state_d = RESET_PLL;
          end
        end
      end
      STABLE: begin
        if (!locked_s) state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        if (lock_fall) begin
          state_d = RESET_PLL;
          retry_d = '0;
          if (loss_q != LOSS_MAX) loss_d = loss_q + loss_t'(1);
        end else if (relock_req) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end
      FAULT: begin
        if (relock_req) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end
      end
      default: begin
        state_d = RESET_PLL;
        retry_d = '0;
      end
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {RESET_PLL, WAIT_LOCK, STABLE}) begin
      cnt_d = cnt_q + cnt_t'(1);
    end else begin
      cnt_d = '0;
    end
  end

  // State, counters and port outputs. The outputs are decoded from the
  // next state, so they change on the same edge as the state register.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= RESET_PLL;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= (state_d == RESET_PLL) || (state_d == FAULT);
      sys_rst_q <= (state_d != RUN);
      ready_q   <= (state_d == RUN);
      fault_q   <= (state_d == FAULT);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_rst         = sys_rst_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed-random bench for pll_lock_sequencer. It randomizes the lock
// delays and glitch timing, and derives the expected outputs from the
// intended timing rules.
module tb_pll_lock_sequencer;

  localparam int RST_P = 4;
  localparam int LSC   = 8;
  localparam int TO    = 32;
  localparam int MR    = 2;
  localparam int LW    = 8;
  localparam int BOUND = 500;

  logic          refclk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          relock_req;
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic          fault;
  logic [1:0]    retry_count;
  logic [LW-1:0] lock_loss_count;

  int checks     = 0;
  int errors     = 0;
  int lossEvents = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (RST_P),
    .LOCK_STABLE_CYCLES  (LSC),
    .LOCK_TIMEOUT_CYCLES (TO),
    .MAX_RETRIES         (MR),
    .LOSS_CNT_W          (LW)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .relock_req      (relock_req),
    .pll_rst         (pll_rst),
    .sys_rst         (sys_rst),
    .ready           (ready),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  // Free-running 100 MHz-style refclk for simulation.
  always #5 refclk = ~refclk;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // The loss counter saturates at all-ones.
  function automatic int expLoss();
    return (lossEvents > 255) ? 255 : lossEvents;
  endfunction

  // Advance one edge and settle past it before sampling or driving.
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pll_rst"}, 32'(pll_rst), 1);
    checkOutput({tag, "_sys_rst"}, 32'(sys_rst), 1);
    checkOutput({tag, "_ready"},   32'(ready),   0);
    checkOutput({tag, "_fault"},   32'(fault),   0);
    checkOutput({tag, "_retry"},   32'(retry_count), 0);
    checkOutput({tag, "_loss"},    32'(lock_loss_count), 0);
  endtask

  // Count the edges until pll_rst leaves the given level. The count is
  // bounded, so a stuck DUT shows up as a wrong width.
  task automatic waitWhileRst(input logic level, output int n);
    n = 0;
    while (pll_rst === level && n < BOUND) begin
      tick();
      n++;
    end
  endtask

  // Starting in WAIT_LOCK, raise the lock after a random delay. Ready must
  // appear exactly 2 + LSC edges after the rise, and not one edge earlier.
  task automatic applyStimulus(input int maxDelay, input string tag);
    int d;
    d = $urandom_range(maxDelay, 0);
    repeat (d) tick();
    pll_locked = 1'b1;
    repeat (LSC + 1) tick();
    checkOutput({tag, "_ready_early"}, 32'(ready), 0);
    tick();
    checkOutput({tag, "_ready"},   32'(ready),   1);
    checkOutput({tag, "_sys_rst"}, 32'(sys_rst), 0);
    checkOutput({tag, "_retry"},   32'(retry_count), 0);
  endtask

  // Linear sequence of directed scenarios with randomized timing.
  initial begin
    int n;
    int k;
    int g;
    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (3) tick();
    checkResetValues("por");
    rst = 1'b0;

    // Normal start: the pll_rst pulse width, then the lock latency.
    waitWhileRst(1'b1, n);
    checkOutput("s1_pll_rst_width", 32'(n), RST_P);
    applyStimulus(25, "s1");

    // Lock loss in RUN.
    repeat ($urandom_range(10, 1)) tick();
    pll_locked = 1'b0;
    lossEvents++;
    repeat (3) tick();
    checkOutput("s4_sys_rst", 32'(sys_rst), 1);
    checkOutput("s4_ready",   32'(ready),   0);
    checkOutput("s4_pll_rst", 32'(pll_rst), 1);
    checkOutput("s4_loss",    32'(lock_loss_count), 32'(expLoss()));
    waitWhileRst(1'b1, n);
    checkOutput("s4_pll_rst_width", 32'(n), RST_P);
    applyStimulus(25, "s4");
    checkOutput("s4_loss_hold", 32'(lock_loss_count), 32'(expLoss()));

    // A plain relock request from RUN, then a lock glitch during STABLE.
    relock_req = 1'b1;
    pll_locked = 1'b0;
    tick();
    relock_req = 1'b0;
    checkOutput("s3_relock_pll_rst", 32'(pll_rst), 1);
    checkOutput("s3_relock_ready",   32'(ready),   0);
    checkOutput("s3_relock_loss",    32'(lock_loss_count), 32'(expLoss()));
    waitWhileRst(1'b1, n);
    checkOutput("s3_pll_rst_width", 32'(n), RST_P);
    repeat ($urandom_range(20, 0)) tick();
    pll_locked = 1'b1;
    k = $urandom_range(6, 1);
    repeat (k) tick();
    pll_locked = 1'b0;
    g = $urandom_range(4, 1);
    repeat (g) tick();
    checkOutput("s3_glitch_pll_rst", 32'(pll_rst), 0);
    applyStimulus(0, "s3");

    // Lock loss and relock request land on the same cycle: one increment.
    repeat ($urandom_range(10, 1)) tick();
    pll_locked = 1'b0;
    repeat (2) tick();
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    lossEvents++;
    checkOutput("s5b_loss",    32'(lock_loss_count), 32'(expLoss()));
    checkOutput("s5b_pll_rst", 32'(pll_rst), 1);
    waitWhileRst(1'b1, n);
    checkOutput("s5b_pll_rst_width", 32'(n), RST_P);
    applyStimulus(10, "s5b");
    checkOutput("s5b_loss_hold", 32'(lock_loss_count), 32'(expLoss()));

    // Enough lock losses to saturate the counter.
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      lossEvents++;
      repeat (3) tick();
      checkOutput("s5c_loss", 32'(lock_loss_count), 32'(expLoss()));
      waitWhileRst(1'b1, n);
      checkOutput("s5c_pll_rst_width", 32'(n), RST_P);
      applyStimulus(5, "s5c");
    end
    checkOutput("s5c_loss_sat", 32'(lock_loss_count), 255);

    // Reset while in RUN.
    rst        = 1'b1;
    pll_locked = 1'b0;
    tick();
    lossEvents = 0;
    checkResetValues("s6_rst_run");
    rst = 1'b0;

    // Never lock: three pulses, each followed by a full timeout, then FAULT.
    waitWhileRst(1'b1, n);
    checkOutput("s2_pulse0_width", 32'(n), RST_P);
    for (int i = 0; i <= MR; i++) begin
      waitWhileRst(1'b0, n);
      checkOutput("s2_wait_width", 32'(n), TO);
      if (i < MR) begin
        checkOutput("s2_retry", 32'(retry_count), 32'(i + 1));
        checkOutput("s2_fault_early", 32'(fault), 0);
        waitWhileRst(1'b1, n);
        checkOutput("s2_pulse_width", 32'(n), RST_P);
      end
    end
    checkOutput("s2_fault",   32'(fault),   1);
    checkOutput("s2_pll_rst", 32'(pll_rst), 1);
    checkOutput("s2_sys_rst", 32'(sys_rst), 1);
    checkOutput("s2_retry_final", 32'(retry_count), MR);
    repeat ($urandom_range(60, 20)) tick();
    checkOutput("s2_fault_sticky",   32'(fault),   1);
    checkOutput("s2_pll_rst_sticky", 32'(pll_rst), 1);
    checkOutput("s2_ready_sticky",   32'(ready),   0);

    // Relock request from FAULT restarts a clean sequence.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    checkOutput("s5a_fault",   32'(fault),   0);
    checkOutput("s5a_retry",   32'(retry_count), 0);
    checkOutput("s5a_pll_rst", 32'(pll_rst), 1);
    waitWhileRst(1'b1, n);
    checkOutput("s5a_pll_rst_width", 32'(n), RST_P);
    applyStimulus(25, "s5a");

    // Reset while waiting for lock.
    relock_req = 1'b1;
    pll_locked = 1'b0;
    tick();
    relock_req = 1'b0;
    waitWhileRst(1'b1, n);
    repeat ($urandom_range(10, 2)) tick();
    checkOutput("s6_wait_pll_rst", 32'(pll_rst), 0);
    checkOutput("s6_wait_sys_rst", 32'(sys_rst), 1);
    rst = 1'b1;
    tick();
    checkResetValues("s6_rst_wait");
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Controller for the SDRAM PLL: sequences the PLL reset, waits for and qualifies lock, and releases a system reset to the outclk domains only once lock is stable. It runs on the free-running reference clock, because PLL outputs are invalid until lock. It retries the PLL on lock timeout, recovers automatically from lock loss, and latches a fault after exhausting retries.

Parameters:
RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per reset attempt (≥1)
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release (≥1)
LOCK_TIMEOUT_CYCLES, 65536, max refclk cycles to wait for lock per attempt (≥2)
MAX_RETRIES, 3, PLL re-resets allowed after the initial attempt before FAULT (≥0)
LOSS_CNT_W, 8, width of the saturating lock-loss counter

Ports:
refclk  in  1  clock; 50 MHz free-running reference, the only clock
rst  in  1  reset; synchronous, active-high
pll_locked  in  1  PLL locked output; asynchronous to refclk
relock_req  in  1  single-cycle request to force a fresh PLL reset sequence
pll_rst  out  1  PLL reset, to the PLL rst input
sys_rst  out  1  active-high reset for logic clocked by outclk_0/outclk_1
ready  out  1  PLL locked, qualified, and sys_rst released
fault  out  1  lock never achieved within retry budget
retry_count  out  $clog2(MAX_RETRIES+1)  retries used in the current sequence
lock_loss_count  out  LOSS_CNT_W  saturating count of lock losses seen in RUN

Behaviour:
- One clock (refclk). Reset is synchronous and active-high (rst). rst has priority over every other event.
- Reset values: state=RESET_PLL, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_count=0, lock_loss_count=0. All internal counters clear.
- pll_locked passes through a 2-FF synchronizer; locked_s is the second stage. Synchronizer flops reset to 0.
- Outputs are registered and update on the same edge as the state register, with no combinational decode to the ports.
- Output decode: pll_rst=1 in RESET_PLL and FAULT. sys_rst=1 in every state except RUN. ready=1 only in RUN. fault=1 only in FAULT.
- RESET_PLL: the cycle counter runs 0..RST_PULSE_CYCLES-1. On the terminal count, go to WAIT_LOCK and clear the counter. pll_rst is high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - locked_s=1: go to STABLE and clear the counter.
  - Otherwise, on counter = LOCK_TIMEOUT_CYCLES-1:
    - if retry_count == MAX_RETRIES: go to FAULT.
    - else: retry_count += 1, go to RESET_PLL.
- STABLE:
  - locked_s=0: go to WAIT_LOCK with the timeout counter restarted. retry_count is unchanged.
  - LOCK_STABLE_CYCLES consecutive cycles in STABLE with locked_s=1: go to RUN.
- RUN:
  - locked_s falling: go to RESET_PLL, increment lock_loss_count (saturating at all-ones), clear retry_count.
  - relock_req: go to RESET_PLL, clear retry_count, no loss increment.
  - Lock loss and relock_req in the same cycle: counts as one lock loss (single increment).
- FAULT: sticky. Exit only on rst, or on relock_req, which clears retry_count and goes to RESET_PLL.
- relock_req outside RUN and FAULT is ignored.
- End-to-end latency: pll_locked rise to ready=1 is 2 + LOCK_STABLE_CYCLES rising edges.
- Counter width is $clog2(max(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)). One shared counter is cleared on every state change.
- Unused state encodings recover to RESET_PLL.

Decomposition:
- Package pll_seq_pkg:
  - state enum {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT}
  - counter-width helper function
  - default parameter constants
- Sub-module lock_sync: 2-FF synchronizer with synchronous reset. Outputs locked_s and a registered falling-edge pulse for RUN loss detection.

Test Plan:
All scenarios use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Normal start. Release rst; raise pll_locked 10 cycles after pll_rst falls and hold it -> pll_rst high exactly 4 cycles; ready=1 and sys_rst=0 at the 10th edge after pll_locked rises; retry_count=0.
2. Never lock. Hold pll_locked=0 -> exactly 3 pll_rst pulses of 4 cycles, each separated by 32 cycles low; then fault=1, pll_rst=1, retry_count=2, sys_rst=1 indefinitely.
3. Lock glitch in STABLE. Drop pll_locked for 3 cycles during STABLE -> return to WAIT_LOCK, retry_count stays 0; ready=1 at 2+8 edges after the final rise.
4. Lock loss in RUN. Drop pll_locked -> sys_rst=1 and ready=0 within 3 edges; one 4-cycle pll_rst pulse; lock_loss_count=1; re-lock restores ready.
5. relock_req cases:
   - in FAULT -> retry_count=0, pll_rst pulse, normal lock sequence.
   - same cycle as lock loss in RUN -> lock_loss_count increments by exactly 1.
   - 256 losses -> lock_loss_count saturates at 255.
6. rst mid-sequence. Assert rst during WAIT_LOCK and during RUN -> all outputs at reset values after the next edge; lock_loss_count=0.
